nrx_snd_writer: RTL

Sound-register write master for the New Rally-X sound block. It accepts whole-voice update requests (voice number, 20-bit frequency, 4-bit volume, 3-bit waveform) over a valid/ready handshake. It serialises each request into the nibble-wide AD/DI/WR register-write sequence that the sound block latches on CCLK. It sits in place of, or muxed with, the CPU write path, and is used by the sound-test/attract sequencer and by verification benches.

---
 rtl/nrx_snd_writer.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/nrx_snd_writer.sv
// nrx_snd_writer
// ---------------------------------------------------------------------------
// Sound-register write master for the New Rally-X sound block. A whole-voice
// update request (voice, 20-bit frequency, volume, waveform, mute) is taken
// over a valid/ready handshake and replayed as a series of nibble writes
// (ad/di with a one-cycle wr strobe) that the sound block latches on clk.
//
// Handshake: a request transfers on a rising clk edge where req_valid and
// req_ready are both high; the req_* fields are sampled on that edge only and
// may change freely afterwards. req_valid may rise or fall at any time, and
// nothing happens on an edge where req_valid is low.
//
// Parameter
//   GAP        idle clk cycles between consecutive nibble writes (0..15)
// Ports
//   clk        clock, all logic on posedge
//   reset      synchronous, active-high reset
//   req_valid  update request present
//   req_ready  request can be accepted this cycle
//   req_voice  voice 0..2 (3 is invalid: accepted, flagged on err, no writes)
//   req_freq   frequency; voices 1/2 use bits [19:4] only
//   req_vol    volume
//   req_wave   waveform number
//   req_mute   issue a single volume=0 write only
//   ad / di    register address / data nibble to the sound block
//   wr         write strobe, one clk per nibble
//   busy       a write sequence is in progress (including gap cycles)
//   err        one-cycle pulse after an invalid voice is accepted
//   dbg_state  current FSM state (0 idle, 1 write, 2 gap)
// ---------------------------------------------------------------------------
module nrx_snd_writer #(
  parameter int GAP = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_voice,
  input  logic [19:0] req_freq,
  input  logic [3:0]  req_vol,
  input  logic [2:0]  req_wave,
  input  logic        req_mute,
  output logic [4:0]  ad,
  output logic [3:0]  di,
  output logic        wr,
  output logic        busy,
  output logic        err,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  localparam logic [3:0] GAP_M1 = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  // Index of the final (volume) write of a sequence.
  function automatic logic [2:0] last_step(input logic [1:0] v, input logic m);
    if (m)              last_step = 3'd0;
    else if (v == 2'd0) last_step = 3'd6;
    else                last_step = 3'd5;
  endfunction

  // Step 0 is the waveform write, the last step is volume, the steps between
  // walk the frequency nibbles low to high.
  function automatic logic [4:0] wr_addr(input logic [1:0] v, input logic m,
                                         input logic [2:0] s, input logic [2:0] last);
    wr_addr = 5'h00;
    if (m || s == last) begin
      case (v)
        2'd0:    wr_addr = 5'h15;
        2'd1:    wr_addr = 5'h1A;
        2'd2:    wr_addr = 5'h1F;
        default: wr_addr = 5'h00;
      endcase
    end else if (s == 3'd0) begin
      case (v)
        2'd0:    wr_addr = 5'h05;
        2'd1:    wr_addr = 5'h0A;
        2'd2:    wr_addr = 5'h0F;
        default: wr_addr = 5'h00;
      endcase
    end else begin
      case (v)
        2'd0:    wr_addr = 5'h10 + 5'(s) - 5'd1;
        2'd1:    wr_addr = 5'h16 + 5'(s) - 5'd1;
        2'd2:    wr_addr = 5'h1B + 5'(s) - 5'd1;
        default: wr_addr = 5'h00;
      endcase
    end
  endfunction

  function automatic logic [3:0] wr_data(input logic [1:0] v, input logic m,
                                         input logic [2:0] s, input logic [2:0] last,
                                         input logic [19:0] f, input logic [3:0] vol,
                                         input logic [2:0] wave);
    logic [2:0] nib;
    // Voice 0 starts at freq[3:0]; voices 1/2 have no low nibble register.
    nib = (v == 2'd0) ? (s - 3'd1) : s;
    if (m)              wr_data = 4'h0;
    else if (s == last) wr_data = vol;
    else if (s == 3'd0) wr_data = {1'b0, wave};
    else                wr_data = f[{nib, 2'b00} +: 4];
  endfunction

  state_t      state_q, state_d;
  logic [2:0]  step_q, step_d;
  logic [3:0]  gcnt_q, gcnt_d;
  logic [1:0]  voice_q;
  logic [19:0] freq_q;
  logic [3:0]  vol_q;
  logic [2:0]  wave_q;
  logic        mute_q;
  logic [2:0]  last_q;

  logic        accept;
  logic        load;
  logic        err_d;
  logic [1:0]  src_voice;
  logic [19:0] src_freq;
  logic [3:0]  src_vol;
  logic [2:0]  src_wave;
  logic        src_mute;
  logic [2:0]  src_last;

  assign accept    = req_valid & req_ready;
  assign dbg_state = state_q;

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    gcnt_d  = gcnt_q;
    load    = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: ;
      S_WRITE: begin
        if (step_q == last_q) begin
          state_d = S_IDLE;
        end else if (GAP == 0) begin
          step_d = step_q + 3'd1;
        end else begin
          state_d = S_GAP;
          gcnt_d  = GAP_M1;
        end
      end
      S_GAP: begin
        if (gcnt_q == 4'd0) begin
          state_d = S_WRITE;
          step_d  = step_q + 3'd1;
        end else begin
          gcnt_d = gcnt_q - 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // req_ready is only high in IDLE or on the last write, where the case
    // above has already chosen IDLE; an accept overrides that choice.
    if (accept) begin
      if (req_voice == 2'd3) begin
        err_d = 1'b1;
      end else begin
        load    = 1'b1;
        state_d = S_WRITE;
        step_d  = 3'd0;
      end
    end
  end

  // The write being set up comes from the live inputs on an accept edge and
  // from the latched copy otherwise.
  always_comb begin
    src_voice = load ? req_voice : voice_q;
    src_freq  = load ? req_freq  : freq_q;
    src_vol   = load ? req_vol   : vol_q;
    src_wave  = load ? req_wave  : wave_q;
    src_mute  = load ? req_mute  : mute_q;
    src_last  = last_step(src_voice, src_mute);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      step_q    <= 3'd0;
      gcnt_q    <= 4'd0;
      voice_q   <= 2'd0;
      freq_q    <= 20'd0;
      vol_q     <= 4'd0;
      wave_q    <= 3'd0;
      mute_q    <= 1'b0;
      last_q    <= 3'd0;
      ad        <= 5'd0;
      di        <= 4'd0;
      wr        <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
      req_ready <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      gcnt_q  <= gcnt_d;
      if (load) begin
        voice_q <= req_voice;
        freq_q  <= req_freq;
        vol_q   <= req_vol;
        wave_q  <= req_wave;
        mute_q  <= req_mute;
        last_q  <= src_last;
      end
      wr <= (state_d == S_WRITE);
      if (state_d == S_WRITE) begin
        ad <= wr_addr(src_voice, src_mute, step_d, src_last);
        di <= wr_data(src_voice, src_mute, step_d, src_last, src_freq, src_vol, src_wave);
      end
      busy      <= (state_d != S_IDLE);
      err       <= err_d;
      req_ready <= (state_d == S_IDLE) || (state_d == S_WRITE && step_d == src_last);
    end
  end

endmodule
